// File: rtl/uncached_access_buffer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uncached_access_buffer_pkg
// Purpose  : Shared types and constants for the uncached access buffer:
//            the buffered request entry, the sequencer state encoding and
//            the AXI size code for a full 32-bit word.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package uncached_access_buffer_pkg;

    localparam int c_UAB_ADDR_W = 32;
    localparam int c_UAB_DATA_W = 32;

    // AXI AxSIZE encoding for a 4-byte transfer.
    localparam logic [2:0] c_AXI_SIZE_WORD = 3'b010;

    // One uncached access as it is stored in the FIFO / load register.
    typedef struct packed {
        logic [c_UAB_ADDR_W-1:0] addr;
        logic [3:0]              byteen;
        logic [2:0]              size;
        logic [c_UAB_DATA_W-1:0] wdata;
    } uab_req_t;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WR_BUSY = 2'd1,
        ST_RD_BUSY = 2'd2,
        ST_GAP     = 2'd3
    } uab_state_t;

endpackage : uncached_access_buffer_pkg
`default_nettype wire

// File: rtl/uab_fifo.sv
`default_nettype none
// ============================================================================
// Module   : uab_fifo
// Purpose  : Synchronous in-order FIFO holding posted uncached stores.
// Ports    : i_clk, i_rst      - clock, synchronous active-high reset
//            i_push, i_data    - enqueue at tail (ignored when full)
//            i_pop             - dequeue head (ignored when empty)
//            o_head            - entry at the head
//            o_count           - occupancy, 0..DEPTH
//            o_full, o_empty   - occupancy flags from the registered count
// Revision : 1.0 - initial release
// ============================================================================
module uab_fifo #(
    parameter int  DEPTH = 8,
    parameter type T     = logic
) (
    input  wire logic                   i_clk,
    input  wire logic                   i_rst,
    input  wire logic                   i_push,
    input  wire T                       i_data,
    input  wire logic                   i_pop,
    output T                            o_head,
    output logic [$clog2(DEPTH):0]      o_count,
    output logic                        o_full,
    output logic                        o_empty
);

    localparam int c_PTR_W = $clog2(DEPTH);

    T                   r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_PTR_W:0]   r_count;
    logic               w_do_push;
    logic               w_do_pop;

    assign o_full    = (r_count == (c_PTR_W+1)'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_head    = r_mem[r_rd_ptr];
    assign w_do_push = i_push & ~o_full;
    assign w_do_pop  = i_pop & ~o_empty;

    // Storage is cleared on reset so downstream fields read as zero while idle.
    // Pointers are log2(DEPTH) wide and wrap naturally modulo DEPTH.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule : uab_fifo
`default_nettype wire

// File: rtl/uncached_access_buffer.sv
`default_nettype none
// ============================================================================
// Module   : uncached_access_buffer
// Purpose  : Converts CPU uncached loads/stores into the level-request /
//            pulse-completion protocol of the memory block's uncached port.
//            Stores are posted into an in-order FIFO; a load is held in a
//            single register and only issued after every older store has
//            completed, giving strict program order towards device space.
// Ports    : i_clk, i_rst           - clock, synchronous active-high reset
//            i_req_*  / o_req_ready - CPU request (valid/ready handshake)
//            o_rdata_valid, o_rdata - load return (pulse, data held)
//            o_empty                - nothing buffered or in flight (fence)
//            o_dsram_*              - downstream request fields, level held
//            i_dsram_outdata/valid  - downstream read data / completion pulse
// Revision : 1.0 - initial release
// ============================================================================
module uncached_access_buffer
    import uncached_access_buffer_pkg::*;
#(
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  wire logic              i_clk,
    input  wire logic              i_rst,
    input  wire logic              i_req_valid,
    input  wire logic              i_req_write,
    input  wire logic [ADDR_W-1:0] i_req_addr,
    input  wire logic [3:0]        i_req_byteen,
    input  wire logic [2:0]        i_req_size,
    input  wire logic [DATA_W-1:0] i_req_wdata,
    output logic                   o_req_ready,
    output logic                   o_rdata_valid,
    output logic [DATA_W-1:0]      o_rdata,
    output logic                   o_empty,
    output logic [ADDR_W-1:0]      o_dsram_addr,
    output logic                   o_dsram_read,
    output logic                   o_dsram_write,
    output logic [3:0]             o_dsram_byteen,
    output logic [2:0]             o_dsram_size,
    output logic [DATA_W-1:0]      o_dsram_indata,
    input  wire logic [DATA_W-1:0] i_dsram_outdata,
    input  wire logic              i_dsram_valid
);

    uab_state_t                r_state;
    logic                      r_rd_pending;
    uab_req_t                  r_ld;
    logic                      r_rdata_valid;
    logic [DATA_W-1:0]         r_rdata;
    logic                      r_dsram_read;
    logic                      r_dsram_write;

    uab_req_t                  w_req;
    uab_req_t                  w_head;
    uab_req_t                  w_dsram_req;
    logic [$clog2(DEPTH):0]    w_fifo_count;
    logic                      w_fifo_full;
    logic                      w_fifo_empty;
    logic                      w_st_acc;
    logic                      w_ld_acc;
    logic                      w_pop;

    assign w_req.addr   = c_UAB_ADDR_W'(i_req_addr);
    assign w_req.byteen = i_req_byteen;
    assign w_req.size   = i_req_size;
    assign w_req.wdata  = c_UAB_DATA_W'(i_req_wdata);

    // A pending load blocks everything so no younger store can overtake it.
    // Full is taken from the registered count: a same-cycle pop does not
    // free a slot for the incoming store.
    assign w_st_acc    = i_req_valid &  i_req_write & ~w_fifo_full & ~r_rd_pending;
    assign w_ld_acc    = i_req_valid & ~i_req_write & ~r_rd_pending;
    assign o_req_ready = ~r_rd_pending & (~i_req_write | ~w_fifo_full);

    assign w_pop = (r_state == ST_WR_BUSY) & i_dsram_valid;

    uab_fifo #(
        .DEPTH (DEPTH),
        .T     (uab_req_t)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_push  (w_st_acc),
        .i_data  (w_req),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_count (w_fifo_count),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

    // The load register only drives the port while the read is in flight;
    // at all other times the FIFO head is presented.
    assign w_dsram_req    = (r_state == ST_RD_BUSY) ? r_ld : w_head;
    assign o_dsram_addr   = ADDR_W'(w_dsram_req.addr);
    assign o_dsram_byteen = w_dsram_req.byteen;
    assign o_dsram_size   = w_dsram_req.size;
    assign o_dsram_indata = DATA_W'(w_dsram_req.wdata);
    assign o_dsram_read   = r_dsram_read;
    assign o_dsram_write  = r_dsram_write;
    assign o_rdata_valid  = r_rdata_valid;
    assign o_rdata        = r_rdata;
    assign o_empty        = (w_fifo_count == '0) & ~r_rd_pending & (r_state == ST_IDLE);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state       <= ST_IDLE;
            r_rd_pending  <= 1'b0;
            r_ld          <= '0;
            r_rdata_valid <= 1'b0;
            r_rdata       <= '0;
            r_dsram_read  <= 1'b0;
            r_dsram_write <= 1'b0;
        end else begin
            r_rdata_valid <= 1'b0;

            if (w_ld_acc) begin
                r_ld         <= w_req;
                r_rd_pending <= 1'b1;
            end

            case (r_state)
                // Same-cycle accepts are looked at so an access into an
                // empty, idle buffer reaches the port on the next cycle.
                // Stores win: any pending load is younger than them.
                ST_IDLE: begin
                    if (!w_fifo_empty || w_st_acc) begin
                        r_state       <= ST_WR_BUSY;
                        r_dsram_write <= 1'b1;
                    end else if (r_rd_pending || w_ld_acc) begin
                        r_state      <= ST_RD_BUSY;
                        r_dsram_read <= 1'b1;
                    end
                end
                ST_WR_BUSY: begin
                    if (i_dsram_valid) begin
                        r_state       <= ST_GAP;
                        r_dsram_write <= 1'b0;
                    end
                end
                ST_RD_BUSY: begin
                    if (i_dsram_valid) begin
                        r_state       <= ST_GAP;
                        r_dsram_read  <= 1'b0;
                        r_rdata       <= i_dsram_outdata;
                        r_rdata_valid <= 1'b1;
                        r_rd_pending  <= 1'b0;
                    end
                end
                // One dead cycle so the downstream edge detector sees a new request.
                ST_GAP: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state       <= ST_IDLE;
                    r_dsram_read  <= 1'b0;
                    r_dsram_write <= 1'b0;
                end
            endcase
        end
    end

endmodule : uncached_access_buffer
`default_nettype wire

// File: tb/tb_uncached_access_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_uncached_access_buffer
// Purpose  : Directed self-checking bench for uncached_access_buffer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uncached_access_buffer;
    import uncached_access_buffer_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_req_valid = 1'b0;
    logic        i_req_write = 1'b0;
    logic [31:0] i_req_addr = '0;
    logic [3:0]  i_req_byteen = '0;
    logic [2:0]  i_req_size = '0;
    logic [31:0] i_req_wdata = '0;
    logic        o_req_ready;
    logic        o_rdata_valid;
    logic [31:0] o_rdata;
    logic        o_empty;
    logic [31:0] o_dsram_addr;
    logic        o_dsram_read;
    logic        o_dsram_write;
    logic [3:0]  o_dsram_byteen;
    logic [2:0]  o_dsram_size;
    logic [31:0] o_dsram_indata;
    logic [31:0] i_dsram_outdata = '0;
    logic        i_dsram_valid = 1'b0;

    int vectors = 0;
    int errs    = 0;

    uncached_access_buffer #(.DEPTH(8), .ADDR_W(32), .DATA_W(32)) dut (
        .i_clk           (clk),
        .i_rst           (rst),
        .i_req_valid     (i_req_valid),
        .i_req_write     (i_req_write),
        .i_req_addr      (i_req_addr),
        .i_req_byteen    (i_req_byteen),
        .i_req_size      (i_req_size),
        .i_req_wdata     (i_req_wdata),
        .o_req_ready     (o_req_ready),
        .o_rdata_valid   (o_rdata_valid),
        .o_rdata         (o_rdata),
        .o_empty         (o_empty),
        .o_dsram_addr    (o_dsram_addr),
        .o_dsram_read    (o_dsram_read),
        .o_dsram_write   (o_dsram_write),
        .o_dsram_byteen  (o_dsram_byteen),
        .o_dsram_size    (o_dsram_size),
        .o_dsram_indata  (o_dsram_indata),
        .i_dsram_outdata (i_dsram_outdata),
        .i_dsram_valid   (i_dsram_valid)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Present a request and hold it until accepted (bounded); returns one
    // cycle after acceptance with the request withdrawn.
    task automatic put(input string tag, input logic wr, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] be);
        int n;
        n = 0;
        i_req_valid  = 1'b1;
        i_req_write  = wr;
        i_req_addr   = a;
        i_req_wdata  = d;
        i_req_byteen = be;
        i_req_size   = c_AXI_SIZE_WORD;
        #1;
        while (o_req_ready !== 1'b1 && n < 20) begin
            tick();
            #1;
            n++;
        end
        chk(tag, o_req_ready, 1);
        tick();
        i_req_valid = 1'b0;
    endtask

    // Wait (bounded) for the downstream write or read request to be raised.
    task automatic wait_req(input string tag, input logic want_write);
        int n;
        n = 0;
        while (((want_write ? o_dsram_write : o_dsram_read) !== 1'b1) && n < 20) begin
            tick();
            n++;
        end
        chk(tag, want_write ? o_dsram_write : o_dsram_read, 1);
    endtask

    // One-cycle completion pulse; returns in the following (GAP) cycle.
    task automatic complete(input logic [31:0] rdata);
        i_dsram_outdata = rdata;
        i_dsram_valid   = 1'b1;
        tick();
        i_dsram_valid   = 1'b0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_ready"},  o_req_ready, 1);
        chk({tag, "_empty"},  o_empty, 1);
        chk({tag, "_write"},  o_dsram_write, 0);
        chk({tag, "_read"},   o_dsram_read, 0);
        chk({tag, "_addr"},   o_dsram_addr, 0);
        chk({tag, "_indata"}, o_dsram_indata, 0);
        chk({tag, "_rvalid"}, o_rdata_valid, 0);
        chk({tag, "_rdata"},  o_rdata, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic seen;

        // ---------------- reset ----------------
        tick();
        tick();
        rst = 1'b0;
        chk_reset_outputs("reset");

        // ---------------- single store ----------------
        put("st1_acc", 1'b1, 32'hBFAF_F000, 32'h1234_5678, 4'hF);
        chk("st1_write",  o_dsram_write, 1);
        chk("st1_read",   o_dsram_read, 0);
        chk("st1_addr",   o_dsram_addr, 32'hBFAF_F000);
        chk("st1_data",   o_dsram_indata, 32'h1234_5678);
        chk("st1_be",     o_dsram_byteen, 4'hF);
        chk("st1_size",   o_dsram_size, 3'b010);
        chk("st1_empty",  o_empty, 0);
        tick();
        chk("st1_hold",   o_dsram_write, 1);
        chk("st1_stable", o_dsram_addr, 32'hBFAF_F000);
        complete(32'h0);
        chk("st1_gap_w",  o_dsram_write, 0);
        chk("st1_gap_e",  o_empty, 0);
        tick();
        chk("st1_idle_e", o_empty, 1);
        chk("st1_idle_w", o_dsram_write, 0);

        // ---------------- fill FIFO, full + same-cycle pop ----------------
        for (int i = 0; i < 8; i++) begin
            put("fill_acc", 1'b1, 32'h0000_1000 + 32'(i * 4), 32'h0000_00A0 + 32'(i), 4'hF);
        end
        i_req_valid  = 1'b1;
        i_req_write  = 1'b1;
        i_req_addr   = 32'h0000_1020;
        i_req_wdata  = 32'h0000_00A8;
        i_req_byteen = 4'hF;
        #1;
        chk("full_ready0", o_req_ready, 0);
        chk("full_head0",  o_dsram_addr, 32'h0000_1000);
        chk("full_data0",  o_dsram_indata, 32'h0000_00A0);
        tick();
        #1;
        chk("full_ready1", o_req_ready, 0);
        i_dsram_valid = 1'b1;
        #1;
        chk("full_pop_ready", o_req_ready, 0);
        tick();
        i_dsram_valid = 1'b0;
        #1;
        chk("after_pop_ready", o_req_ready, 1);
        chk("after_pop_gap",   o_dsram_write, 0);
        tick();
        i_req_valid = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            wait_req("drain_wait", 1'b1);
            chk("drain_addr", o_dsram_addr, 32'h0000_1000 + 32'(i * 4));
            chk("drain_data", o_dsram_indata, 32'h0000_00A0 + 32'(i));
            complete(32'h0);
            chk("drain_gap", o_dsram_write, 0);
        end
        tick();
        chk("drain_empty", o_empty, 1);

        // ---------------- pointer wrap (stores 11..20 overall) ----------------
        for (int i = 0; i < 10; i++) begin
            put("wrap_acc", 1'b1, 32'h0000_2000 + 32'(i * 4), 32'h0000_5500 + 32'(i), 4'h3);
            chk("wrap_write", o_dsram_write, 1);
            chk("wrap_addr",  o_dsram_addr, 32'h0000_2000 + 32'(i * 4));
            chk("wrap_data",  o_dsram_indata, 32'h0000_5500 + 32'(i));
            chk("wrap_be",    o_dsram_byteen, 4'h3);
            complete(32'h0);
            tick();
        end
        chk("wrap_empty", o_empty, 1);

        // ---------------- load behind three stores ----------------
        for (int i = 0; i < 3; i++) begin
            put("ord_st_acc", 1'b1, 32'h0000_3000 + 32'(i * 4), 32'h0000_0300 + 32'(i), 4'hF);
        end
        put("ord_ld_acc", 1'b0, 32'hBFD0_F010, 32'h0, 4'hF);
        chk("ord_ld_blocks", o_req_ready, 0);
        for (int i = 0; i < 3; i++) begin
            wait_req("ord_wr_wait", 1'b1);
            chk("ord_no_read", o_dsram_read, 0);
            chk("ord_addr", o_dsram_addr, 32'h0000_3000 + 32'(i * 4));
            complete(32'h0);
            chk("ord_gap_read", o_dsram_read, 0);
        end
        wait_req("ord_rd_wait", 1'b0);
        chk("ord_rd_addr",  o_dsram_addr, 32'hBFD0_F010);
        chk("ord_rd_size",  o_dsram_size, 3'b010);
        chk("ord_rd_write", o_dsram_write, 0);
        chk("ord_rd_empty", o_empty, 0);

        // ---------------- store presented while load pending ----------------
        i_req_valid  = 1'b1;
        i_req_write  = 1'b1;
        i_req_addr   = 32'h0000_3100;
        i_req_wdata  = 32'h0000_0077;
        i_req_byteen = 4'hF;
        #1;
        chk("pend_ready0", o_req_ready, 0);
        tick();
        #1;
        chk("pend_ready1", o_req_ready, 0);
        i_dsram_outdata = 32'hCAFE_F00D;
        i_dsram_valid   = 1'b1;
        #1;
        chk("pend_ready2", o_req_ready, 0);
        tick();
        i_dsram_valid = 1'b0;
        chk("ld_rvalid", o_rdata_valid, 1);
        chk("ld_rdata",  o_rdata, 32'hCAFE_F00D);
        chk("ld_read_off", o_dsram_read, 0);
        put("pend_st_acc", 1'b1, 32'h0000_3100, 32'h0000_0077, 4'hF);
        chk("ld_pulse_end", o_rdata_valid, 0);
        chk("ld_rdata_held", o_rdata, 32'hCAFE_F00D);
        wait_req("pend_st_wait", 1'b1);
        chk("pend_st_addr", o_dsram_addr, 32'h0000_3100);
        chk("pend_st_data", o_dsram_indata, 32'h0000_0077);
        complete(32'h0);
        tick();
        chk("pend_empty", o_empty, 1);

        // ---------------- reset during RD_BUSY ----------------
        put("rst_ld_acc", 1'b0, 32'h1F00_0000, 32'h0, 4'hF);
        wait_req("rst_rd_wait", 1'b0);
        chk("rst_rd_addr", o_dsram_addr, 32'h1F00_0000);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_reset_outputs("rst_mid");
        seen = 1'b0;
        i_dsram_outdata = 32'hDEAD_BEEF;
        i_dsram_valid   = 1'b1;
        tick();
        i_dsram_valid   = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (o_rdata_valid || o_dsram_read || o_dsram_write) seen = 1'b1;
            tick();
        end
        chk("rst_no_activity", seen, 0);
        chk("rst_rdata", o_rdata, 0);
        chk("rst_empty", o_empty, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule : tb_uncached_access_buffer
`default_nettype wire
